// File: rtl/cam_pkg.sv
// cam_pkg: definitions shared by the OV7670-style transmitter and the capture block.
//   cam_state_t     - frame sequencer states
//   CAM_*           - default frame timing (pixels, lines, blanking)
//   BYTE_HI/BYTE_LO - byte phase within an RGB565 pixel
//   line_time()     - pclk cycles per line-time
package cam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } cam_state_t;

  localparam int CAM_AW       = 15;
  localparam int CAM_H_PX     = 160;
  localparam int CAM_V_LINES  = 120;
  localparam int CAM_H_BLANK  = 16;
  localparam int CAM_VS_LINES = 3;
  localparam int CAM_V_BACK   = 2;
  localparam int CAM_V_FRONT  = 2;

  // Byte 0 of a pixel carries src_data[15:8], byte 1 carries src_data[7:0].
  localparam logic BYTE_HI = 1'b0;
  localparam logic BYTE_LO = 1'b1;

  function automatic int line_time(input int h_px, input int h_blank);
    return 2 * h_px + h_blank;
  endfunction

endpackage

// File: rtl/cam_tx_if.sv
// cam_tx_if: frame-store read port plus the camera-format video bus.
//   src_addr   - frame-store read address (transmitter drives)
//   src_data   - RGB565 word, valid one pclk after src_addr (store drives)
//   vsync      - frame sync, active high
//   href       - line valid, active high
//   px_data    - byte bus
//   frame_done - one-cycle pulse in the last cycle of a frame
// master: the transmitter; slave: the frame store / receiver side.
interface cam_tx_if
  import cam_pkg::*;
#(
  parameter int AW = CAM_AW
);
  logic [AW-1:0] src_addr;
  logic [15:0]   src_data;
  logic          vsync;
  logic          href;
  logic [7:0]    px_data;
  logic          frame_done;

  modport master (
    output src_addr, vsync, href, px_data, frame_done,
    input  src_data
  );

  modport slave (
    input  src_addr, vsync, href, px_data, frame_done,
    output src_data
  );
endinterface

// File: rtl/cam_tx_timing.sv
// cam_tx_timing: frame sequencer for cam_tx (byte counter, line counter, FSM).
//   pclk, rst   - clock, asynchronous active-low reset
//   en          - frame enable, looked at only when a new frame could start
//   vsync       - registered frame sync
//   href        - registered line valid
//   frame_done  - registered pulse in the last cycle of VFRONT
//   px_next     - the coming cycle carries an active byte
//   phase_next  - byte phase of the coming cycle (BYTE_HI / BYTE_LO)
//   addr_clr    - the coming cycle is outside ACTIVE
// The *_next strobes are decoded from the next-state values so the top level
// can register its address and byte bus on the same edge as href.
module cam_tx_timing
  import cam_pkg::*;
#(
  parameter int H_PX     = CAM_H_PX,
  parameter int V_LINES  = CAM_V_LINES,
  parameter int H_BLANK  = CAM_H_BLANK,
  parameter int VS_LINES = CAM_VS_LINES,
  parameter int V_BACK   = CAM_V_BACK,
  parameter int V_FRONT  = CAM_V_FRONT
) (
  input  logic pclk,
  input  logic rst,
  input  logic en,
  output logic vsync,
  output logic href,
  output logic frame_done,
  output logic px_next,
  output logic phase_next,
  output logic addr_clr
);

  localparam int LT = line_time(H_PX, H_BLANK);
  localparam int BW = $clog2(LT + 1);
  localparam int LW = $clog2(V_LINES + VS_LINES + V_BACK + V_FRONT + 1);

  localparam logic [BW-1:0] LT_LAST = BW'(LT - 1);
  localparam logic [BW-1:0] ACT_END = BW'(2 * H_PX);

  cam_state_t     state, state_n;
  logic [BW-1:0]  byte_cnt, byte_n;
  logic [LW-1:0]  line_cnt, line_n;
  logic [LW-1:0]  phase_last;

  always_comb begin
    phase_last = '0;
    case (state)
      ST_VSYNC:  phase_last = LW'(VS_LINES - 1);
      ST_VBACK:  phase_last = LW'(V_BACK - 1);
      ST_ACTIVE: phase_last = LW'(V_LINES - 1);
      ST_VFRONT: phase_last = LW'(V_FRONT - 1);
      default:   phase_last = '0;
    endcase
  end

  // Every phase is a whole number of line-times: the byte counter wraps each
  // line-time and the line counter counts line-times within the phase.
  always_comb begin
    state_n = state;
    byte_n  = byte_cnt;
    line_n  = line_cnt;
    if (state == ST_IDLE) begin
      byte_n = '0;
      line_n = '0;
      if (en) state_n = ST_VSYNC;
    end else if (byte_cnt != LT_LAST) begin
      byte_n = byte_cnt + BW'(1);
    end else begin
      byte_n = '0;
      if (line_cnt != phase_last) begin
        line_n = line_cnt + LW'(1);
      end else begin
        line_n = '0;
        case (state)
          ST_VSYNC:  state_n = ST_VBACK;
          ST_VBACK:  state_n = ST_ACTIVE;
          ST_ACTIVE: state_n = ST_VFRONT;
          ST_VFRONT: state_n = en ? ST_VSYNC : ST_IDLE;
          default:   state_n = ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    px_next    = (state_n == ST_ACTIVE) && (byte_n < ACT_END);
    phase_next = byte_n[0];
    addr_clr   = (state_n != ST_ACTIVE);
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      byte_cnt   <= '0;
      line_cnt   <= '0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      byte_cnt   <= byte_n;
      line_cnt   <= line_n;
      vsync      <= (state_n == ST_VSYNC);
      href       <= px_next;
      frame_done <= (state_n == ST_VFRONT) && (line_n == LW'(V_FRONT - 1)) &&
                    (byte_n == LT_LAST);
    end
  end

endmodule

// File: rtl/cam_tx.sv
// cam_tx: emits an OV7670-format frame (vsync, href, 8-bit bytes) from a
// 16-bit RGB565 frame store, two bytes per pixel, high byte first.
//   pclk - sole clock, all outputs change on its rising edge
//   rst  - asynchronous active-low reset
//   en   - frame enable, looked at only when a new frame could start
//   bus  - cam_tx_if master: src_addr/src_data store port, vsync, href,
//          px_data, frame_done
module cam_tx
  import cam_pkg::*;
#(
  parameter int AW       = CAM_AW,
  parameter int H_PX     = CAM_H_PX,
  parameter int V_LINES  = CAM_V_LINES,
  parameter int H_BLANK  = CAM_H_BLANK,
  parameter int VS_LINES = CAM_VS_LINES,
  parameter int V_BACK   = CAM_V_BACK,
  parameter int V_FRONT  = CAM_V_FRONT
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        en,
  cam_tx_if.master    bus
);

  logic          vsync, href, frame_done;
  logic          px_next, phase_next, addr_clr;
  logic [AW-1:0] addr;
  logic [7:0]    px;

  cam_tx_timing #(
    .H_PX     (H_PX),
    .V_LINES  (V_LINES),
    .H_BLANK  (H_BLANK),
    .VS_LINES (VS_LINES),
    .V_BACK   (V_BACK),
    .V_FRONT  (V_FRONT)
  ) u_timing (
    .pclk       (pclk),
    .rst        (rst),
    .en         (en),
    .vsync      (vsync),
    .href       (href),
    .frame_done (frame_done),
    .px_next    (px_next),
    .phase_next (phase_next),
    .addr_clr   (addr_clr)
  );

  // The address steps on the edge that drives a pixel's high byte: the store
  // samples the old address on that edge, so the low byte still sees the
  // same word, and the new word is ready for the next high byte. The last
  // pixel of a line therefore leaves the next line's first address in place
  // across blanking, and the address sits at 0 outside ACTIVE so pixel 0 of
  // the frame is already fetched during VBACK.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      addr <= '0;
      px   <= '0;
    end else begin
      if (addr_clr) begin
        addr <= '0;
      end else if (px_next && (phase_next == BYTE_HI)) begin
        addr <= addr + AW'(1);
      end
      if (!px_next) begin
        px <= '0;
      end else if (phase_next == BYTE_HI) begin
        px <= bus.src_data[15:8];
      end else begin
        px <= bus.src_data[7:0];
      end
    end
  end

  assign bus.src_addr   = addr;
  assign bus.vsync      = vsync;
  assign bus.href       = href;
  assign bus.px_data    = px;
  assign bus.frame_done = frame_done;

endmodule

// File: tb/tb_cam_tx.sv
module tb_cam_tx;
  import cam_pkg::*;

  localparam int AW       = 15;
  localparam int H_PX     = 8;
  localparam int V_LINES  = 6;
  localparam int H_BLANK  = 4;
  localparam int VS_LINES = 3;
  localparam int V_BACK   = 2;
  localparam int V_FRONT  = 2;
  localparam int LT       = 2 * H_PX + H_BLANK;
  localparam int FRAME    = (VS_LINES + V_BACK + V_LINES + V_FRONT) * LT;
  localparam int NPIX     = V_LINES * H_PX;

  logic pclk = 1'b0;
  logic rst  = 1'b0;
  logic en   = 1'b0;

  cam_tx_if #(.AW(AW)) bus ();

  cam_tx #(
    .AW       (AW),
    .H_PX     (H_PX),
    .V_LINES  (V_LINES),
    .H_BLANK  (H_BLANK),
    .VS_LINES (VS_LINES),
    .V_BACK   (V_BACK),
    .V_FRONT  (V_FRONT)
  ) dut (
    .pclk (pclk),
    .rst  (rst),
    .en   (en),
    .bus  (bus)
  );

  always #5 pclk = ~pclk;

  // Frame store: synchronous read, one cycle of latency.
  logic [15:0] mem [0:(1<<AW)-1];
  always @(posedge pclk) bus.src_data <= mem[bus.src_addr];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: a frame is just a cycle offset t from vsync rising.
  bit in_frame = 1'b0;
  int t = 0;
  logic [7:0] bq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] model_out();
    int line, b, al;
    logic vs, hr, fd;
    logic [7:0] px;
    logic [15:0] w;
    vs = 1'b0; hr = 1'b0; fd = 1'b0; px = 8'h00;
    if (in_frame) begin
      line = t / LT;
      b    = t % LT;
      al   = line - (VS_LINES + V_BACK);
      vs   = (line < VS_LINES);
      if (al >= 0 && al < V_LINES && b < 2 * H_PX) begin
        hr = 1'b1;
        w  = mem[al * H_PX + b / 2];
        px = (b % 2 == 0) ? w[15:8] : w[7:0];
      end
      fd = (t == FRAME - 1);
    end
    return {vs, hr, fd, px};
  endfunction

  task automatic step();
    @(posedge pclk);
    if (!rst) in_frame = 1'b0;
    else if (in_frame) begin
      if (t == FRAME - 1) begin
        if (en) t = 0;
        else in_frame = 1'b0;
      end else t++;
    end else if (en) begin
      in_frame = 1'b1;
      t = 0;
    end
    #1;
    check("outs", {21'd0, bus.vsync, bus.href, bus.frame_done, bus.px_data}, {21'd0, model_out()});
    if (!in_frame || t < VS_LINES * LT) check("addr_zero", 32'(bus.src_addr), 32'd0);
    if (bus.href) bq.push_back(bus.px_data);
  endtask

  int cnt, g, h, w, p;
  logic [15:0] word, pat;

  initial begin
    for (int unsigned i = 0; i < (1 << AW); i++) mem[i] = i[15:0];

    // Reset state
    repeat (3) step();
    check("rst_outs", {bus.vsync, bus.href, bus.frame_done, bus.px_data, 17'(bus.src_addr)}, 32'd0);
    @(negedge pclk) rst = 1'b1;
    repeat (2) step();
    check("idle_outs", {bus.vsync, bus.href, bus.frame_done, bus.px_data, 17'(bus.src_addr)}, 32'd0);

    // Frame 1 timing with identity memory
    bq.delete();
    en = 1'b1;
    step();
    check("vs_rise", 32'(bus.vsync), 32'd1);
    cnt = 1;
    while (bus.vsync && cnt < FRAME) begin step(); if (bus.vsync) cnt++; end
    check("vs_len", cnt, VS_LINES * LT);
    g = 1;
    while (!bus.href && g < FRAME) begin step(); if (!bus.href) g++; end
    check("vback_gap", g, V_BACK * LT);
    for (int l = 0; l < V_LINES; l++) begin
      h = 0;
      while (bus.href && h < FRAME) begin h++; step(); end
      check("href_len", h, 2 * H_PX);
      if (l < V_LINES - 1) begin
        g = 0;
        while (!bus.href && g < FRAME) begin g++; step(); end
        check("hblank_len", g, H_BLANK);
      end
    end
    w = 0;
    while (!bus.frame_done && w < FRAME) begin step(); w++; end
    check("fd_seen", 32'(bus.frame_done), 32'd1);
    check("line0_b0", 32'(bq[0]), 32'h00);
    check("line0_b1", 32'(bq[1]), 32'h00);
    check("line0_b2", 32'(bq[2]), 32'h00);
    check("line0_b3", 32'(bq[3]), 32'h01);
    check("line0_last", 32'(bq[2*H_PX-1]), 32'(H_PX - 1));
    check("line1_b1", 32'(bq[2*H_PX+1]), 32'(H_PX));
    check("last_px", {16'd0, bq[2*NPIX-2], bq[2*NPIX-1]}, 32'(NPIX - 1));

    // Back-to-back frame: vsync one cycle after frame_done, one pulse per frame
    step();
    check("vs_rerise", 32'(bus.vsync), 32'd1);
    check("addr_restart", 32'(bus.src_addr), 32'd0);
    p = 1;
    while (!bus.frame_done && p < 2 * FRAME) begin step(); p++; end
    check("fd_period", p, FRAME);

    // Drop en mid-ACTIVE of frame 3
    w = 0;
    while (!bus.href && w < FRAME) begin step(); w++; end
    repeat (30) step();
    en = 1'b0;
    w = 0;
    while (!bus.frame_done && w < FRAME) begin step(); w++; end
    check("fd_after_drop", 32'(bus.frame_done), 32'd1);
    repeat (10) step();
    check("idle_after_drop", {bus.vsync, bus.href, bus.frame_done, bus.px_data, 17'(bus.src_addr)}, 32'd0);
    en = 1'b1;
    step();
    check("restart_vs", 32'(bus.vsync), 32'd1);

    // Asynchronous reset at active line 3, byte 5
    w = 0;
    while (t != (VS_LINES + V_BACK + 3) * LT + 5 && w < FRAME) begin step(); w++; end
    check("reached_rst_point", t, (VS_LINES + V_BACK + 3) * LT + 5);
    #3 rst = 1'b0;
    in_frame = 1'b0;
    #1;
    check("async_rst", {bus.vsync, bus.href, bus.frame_done, bus.px_data, 17'(bus.src_addr)}, 32'd0);
    repeat (2) step();
    @(negedge pclk) rst = 1'b1;
    step();
    check("post_rst_vs", 32'(bus.vsync), 32'd1);
    check("post_rst_addr", 32'(bus.src_addr), 32'd0);
    en = 1'b0;
    repeat (FRAME + 5) step();

    // Randomized enable and frame contents
    for (int unsigned i = 0; i < 64; i++) mem[i] = 16'($urandom);
    repeat (1500) begin
      step();
      en = ($urandom_range(0, 3) != 0);
      if (!in_frame && $urandom_range(0, 1) == 1)
        for (int unsigned i = 0; i < 64; i++) mem[i] = 16'($urandom);
    end

    // Loopback into a capture model: RGB565 primaries repeating
    en = 1'b0;
    w = 0;
    while (in_frame && w < 2 * FRAME) begin step(); w++; end
    for (int unsigned i = 0; i < 64; i++) begin
      case (i % 3)
        0:       mem[i] = 16'hF800;
        1:       mem[i] = 16'h07E0;
        default: mem[i] = 16'h001F;
      endcase
    end
    bq.delete();
    en = 1'b1;
    step();
    en = 1'b0;
    w = 0;
    while (!bus.frame_done && w < 2 * FRAME) begin step(); w++; end
    check("cap_len", bq.size(), 2 * NPIX);
    for (int k = 0; k < NPIX; k++) begin
      word = {bq[2*k], bq[2*k+1]};
      case (k % 3)
        0:       pat = 16'hF800;
        1:       pat = 16'h07E0;
        default: pat = 16'h001F;
      endcase
      check("cap_word", 32'(word), 32'(pat));
    end
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
